// File: rtl/mcu_pkg.sv
// mcu_pkg -- definitions shared by the instruction-fetch slice.
//   XLEN              : datapath and address width
//   RESET_PC_DEFAULT  : default byte address of the first fetch after reset
//   INSTR_NOP         : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t     : fetch-queue payload, {pc, instr}
//   pc_next()         : sequential next-PC, wraps modulo 2^XLEN
package mcu_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Plain unsigned add; the carry out of bit XLEN-1 is dropped, so
    // 32'hFFFF_FFFC advances to 32'h0000_0000.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- valid/ready link from the fetch unit to decode.
//   out_valid : head entry valid (driven by fetch)
//   out_instr : head instruction word (driven by fetch)
//   out_pc    : byte address of out_instr (driven by fetch)
//   out_ready : decode accepts the head this cycle (driven by decode)
// modport master : fetch side; modport slave : decode side.
interface fetch_unit_if;
    import mcu_pkg::*;

    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small fetch queue holding {pc, instr} entries.
//   clka    : clock, all state on rising edge
//   reset   : synchronous active-high reset, empties queue and clears storage
//   i_push  : enqueue request (accepted when not full, or full with a pop)
//   i_pop   : dequeue request (ignored while empty)
//   i_flush : discard all entries; wins over push and pop
//   i_data  : entry to enqueue
//   o_valid : queue not empty
//   o_full  : queue holds DEPTH entries
//   o_head  : oldest entry
module fetch_fifo
    import mcu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clka,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_valid,
    output logic         o_full,
    output fetch_entry_t o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && o_valid;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage is cleared on reset so the head reads zero while reset is held.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clka) begin
                if (reset) begin
                    r_mem[gi] <= '0;
                end else if (w_push && !i_flush && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clka) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- program counter, instruction-memory addressing and a
// two-entry fetch queue feeding decode.
//   clka           : sole clock
//   reset          : synchronous active-high reset
//   fetch_en       : permits fetching; low freezes PC and enqueue
//   redirect_valid : single-cycle branch/jump redirect
//   redirect_pc    : redirect target byte address
//   imem_a         : instruction-memory byte address (= PC)
//   imem_rd        : instruction word, combinational response to imem_a
//   out_if         : valid/ready link to decode (fetch_unit_if.master)
//   fetch_fault    : sticky misaligned-redirect fault
// Build option: define FETCH_ALIGN_CHECK_EN to enable redirect alignment
// checking. Without it the low two target bits are dropped and
// fetch_fault is held low.
module fetch_unit
    import mcu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clka,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_a,
    input  logic [XLEN-1:0] imem_rd,
    fetch_unit_if.master    out_if,
    output logic            fetch_fault
);

    logic [XLEN-1:0] r_pc;

    logic            w_fifo_valid;
    logic            w_fifo_full;
    logic            w_deq;
    logic            w_enq;
    logic            w_fault;
    logic            w_redirect_bad;
    logic [XLEN-1:0] w_redirect_target;
    fetch_entry_t    w_enq_data;
    fetch_entry_t    w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    assign w_redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redirect_target = redirect_pc;

    // Once set, the fault holds until reset; the queue may still drain.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_redirect_bad) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    logic w_unused_redirect_lsb;

    assign w_redirect_bad        = 1'b0;
    assign w_redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
    assign w_fault               = 1'b0;
`endif

    assign fetch_fault = w_fault;
    assign imem_a      = r_pc;

    // The head transfer completes even in a redirect cycle; the flush then
    // drops whatever is left behind it.
    assign w_deq = w_fifo_valid && out_if.out_ready;
    assign w_enq = fetch_en && !redirect_valid && !w_fault && (!w_fifo_full || w_deq);

    assign w_enq_data = '{pc: r_pc, instr: imem_rd};

    // Redirect takes priority over sequential advance. A misaligned target,
    // or any redirect after a fault, leaves the PC frozen.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            if (!w_redirect_bad && !w_fault) begin
                r_pc <= w_redirect_target;
            end
        end else if (w_enq) begin
            r_pc <= pc_next(r_pc);
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clka    (clka),
        .reset   (reset),
        .i_push  (w_enq),
        .i_pop   (w_deq),
        .i_flush (redirect_valid),
        .i_data  (w_enq_data),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_head  (w_head)
    );

    assign out_if.out_valid = w_fifo_valid;
    assign out_if.out_instr = w_head.instr;
    assign out_if.out_pc    = w_head.pc;

endmodule
